// File: rtl/tl_state_queue.sv
// Parameterised FIFO of in-flight TileLink response state (size, source, extra id); optional FLOW/PIPE modes.
// Latency 1 cycle (0 with FLOW on an empty queue); enq_ready drops when full unless PIPE and deq fires.
// Optional high-water occupancy register on io_max_count is built only when TL_STATE_QUEUE_HIGHWATER_EN is defined.
module tl_state_queue #(
   parameter int DEPTH    = 2,
   parameter int SIZE_W   = 4,
   parameter int SOURCE_W = 5,
   parameter int FLOW     = 0,
   parameter int PIPE     = 0,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                io_enq_valid,
   output logic                io_enq_ready,
   input  logic [SIZE_W-1:0]   io_enq_bits_tl_state_size,
   input  logic [SOURCE_W-1:0] io_enq_bits_tl_state_source,
   input  logic                io_enq_bits_extra_id,
   output logic                io_deq_valid,
   input  logic                io_deq_ready,
   output logic [SIZE_W-1:0]   io_deq_bits_tl_state_size,
   output logic [SOURCE_W-1:0] io_deq_bits_tl_state_source,
   output logic                io_deq_bits_extra_id,
   output logic [CNT_W-1:0]    io_count,
   output logic [CNT_W-1:0]    io_max_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic                extra_id;
      logic [SOURCE_W-1:0] source;
      logic [SIZE_W-1:0]   size;
   } entry_t;

   entry_t           ram [DEPTH];
   entry_t           enq_ent;
   entry_t           head;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             maybe_full;
   logic             ptr_match;
   logic             empty;
   logic             full;
   logic             bypass;
   logic             do_enq;
   logic             do_deq;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign enq_ent.extra_id = io_enq_bits_extra_id;
   assign enq_ent.source   = io_enq_bits_tl_state_source;
   assign enq_ent.size     = io_enq_bits_tl_state_size;

   assign ptr_match    = (wptr == rptr);
   assign empty        = ptr_match & ~maybe_full;
   assign full         = ptr_match & maybe_full;
   assign bypass       = (FLOW != 0) & empty;
   assign io_enq_ready = ~full | ((PIPE != 0) & io_deq_ready);
   assign io_deq_valid = ~empty | ((FLOW != 0) & io_enq_valid);
   assign do_enq       = io_enq_valid & io_enq_ready;
   assign do_deq       = io_deq_valid & io_deq_ready;

   // A bypassed transfer never touches storage: no write and no pop.
   assign push = do_enq & ~(bypass & io_deq_ready);
   assign pop  = do_deq & ~bypass;

   assign head                        = bypass ? enq_ent : ram[rptr];
   assign io_deq_bits_tl_state_size   = head.size;
   assign io_deq_bits_tl_state_source = head.source;
   assign io_deq_bits_extra_id        = head.extra_id;

   always_ff @(posedge clock) begin
      if (push) ram[wptr] <= enq_ent;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         maybe_full <= 1'b0;
      end else begin
         if (push) wptr <= next_ptr(wptr);
         if (pop)  rptr <= next_ptr(rptr);
         if (push != pop) maybe_full <= push;
      end
   end

   always_comb begin
      count = CNT_W'(wptr) - CNT_W'(rptr);
      if (full)
         count = CNT_W'(DEPTH);
      else if (wptr < rptr)
         count = CNT_W'(wptr) + CNT_W'(DEPTH) - CNT_W'(rptr);
   end

   assign io_count = count;

`ifdef TL_STATE_QUEUE_HIGHWATER_EN
   logic [CNT_W-1:0] max_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         max_q <= '0;
      else if (count > max_q)
         max_q <= count;
   end

   assign io_max_count = max_q;
`else
   assign io_max_count = '0;
`endif

endmodule
